// File: rtl/dem_gpg_ctrl.sv
// Clock/stopwatch control front-end: tick prescalers, button
// debounce, adjust-mode FSM and run/adjust output gating.
module dem_gpg_ctrl #(
  parameter int F_CLK   = 50_000_000,
  parameter int F_DB    = 100,
  parameter int F_ADJ   = 5,
  parameter int DEB_CYC = 1_000_000
) (
  input  logic       ckht,
  input  logic       rst,
  input  logic       btn_run,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_dw,
  output logic       ena_db,
  output logic       ena5hz,
  output logic       ena_up,
  output logic       ena_dw,
  output logic [1:0] gt_mod,
  output logic       running
);

  localparam int DIV_DB  = F_CLK / F_DB;
  localparam int DIV_ADJ = F_CLK / F_ADJ;
  localparam int DB_W    = $clog2(DIV_DB);
  localparam int ADJ_W   = $clog2(DIV_ADJ);
  localparam int DEB_W   = $clog2(DEB_CYC + 1);

  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DIV_DB - 1);
  localparam logic [ADJ_W-1:0] ADJ_MAX = ADJ_W'(DIV_ADJ - 1);
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYC - 1);

  localparam int B_RUN  = 0;
  localparam int B_MODE = 1;
  localparam int B_UP   = 2;
  localparam int B_DW   = 3;

  typedef enum logic [1:0] {
    M_NORM = 2'b00,
    M_SEC  = 2'b01,
    M_MIN  = 2'b10,
    M_HR   = 2'b11
  } mode_e;

  logic [3:0]       raw;
  logic [3:0]       s1_q, s2_q;
  logic [3:0]       lvl_q, lvl_d;
  logic [3:0]       prs_q, prs_d;
  logic [DEB_W-1:0] deb_q [4];
  logic [DEB_W-1:0] deb_d [4];

  mode_e            mode_q, mode_d, mode_nx;
  logic             run_q, run_d;

  logic [DB_W-1:0]  db_q, db_d;
  logic [ADJ_W-1:0] adj_q, adj_d;

  logic ena_db_q, ena_db_d;
  logic ena5hz_q, ena5hz_d;
  logic ena_up_q, ena_up_d;
  logic ena_dw_q, ena_dw_d;

  assign raw = {btn_dw, btn_up, btn_mode, btn_run};

  // Counter runs only while the synced input disagrees with the level
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lvl_d[i] = lvl_q[i];
      deb_d[i] = deb_q[i];
      if (s2_q[i] == lvl_q[i]) begin
        deb_d[i] = '0;
      end else if (deb_q[i] == DEB_MAX) begin
        lvl_d[i] = s2_q[i];
        deb_d[i] = '0;
      end else begin
        deb_d[i] = deb_q[i] + DEB_W'(1);
      end
    end
    prs_d = lvl_d & ~lvl_q;
  end

  always_comb begin
    mode_d = mode_q;
    run_d  = run_q;
    case (mode_q)
      M_NORM:  mode_nx = M_SEC;
      M_SEC:   mode_nx = M_MIN;
      M_MIN:   mode_nx = M_HR;
      default: mode_nx = M_NORM;
    endcase
    if (prs_q[B_MODE]) mode_d = mode_nx;
    // Run toggle judged against the pre-press mode
    if (mode_q == M_NORM) begin
      if (prs_q[B_MODE])     run_d = 1'b0;
      else if (prs_q[B_RUN]) run_d = ~run_q;
    end
  end

  always_comb begin
    if (run_d && !run_q)  db_d = '0;
    else if (db_q == DB_MAX) db_d = '0;
    else                  db_d = db_q + DB_W'(1);
    if (adj_q == ADJ_MAX) adj_d = '0;
    else                  adj_d = adj_q + ADJ_W'(1);

    ena_db_d = (db_q == DB_MAX) & run_q & run_d
             & (mode_d == M_NORM);
    ena5hz_d = (adj_q == ADJ_MAX);
    ena_up_d = lvl_d[B_UP] & ~lvl_d[B_DW]
             & (mode_d != M_NORM);
    ena_dw_d = lvl_d[B_DW] & ~lvl_d[B_UP]
             & (mode_d != M_NORM);
  end

  always_ff @(posedge ckht or negedge rst) begin
    if (!rst) begin
      mode_q <= M_NORM;
      run_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      run_q  <= run_d;
    end
  end

  always_ff @(posedge ckht or negedge rst) begin
    if (!rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      lvl_q    <= '0;
      prs_q    <= '0;
      for (int i = 0; i < 4; i++) deb_q[i] <= '0;
      db_q     <= '0;
      adj_q    <= '0;
      ena_db_q <= 1'b0;
      ena5hz_q <= 1'b0;
      ena_up_q <= 1'b0;
      ena_dw_q <= 1'b0;
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      lvl_q    <= lvl_d;
      prs_q    <= prs_d;
      for (int i = 0; i < 4; i++) deb_q[i] <= deb_d[i];
      db_q     <= db_d;
      adj_q    <= adj_d;
      ena_db_q <= ena_db_d;
      ena5hz_q <= ena5hz_d;
      ena_up_q <= ena_up_d;
      ena_dw_q <= ena_dw_d;
    end
  end

  assign ena_db  = ena_db_q;
  assign ena5hz  = ena5hz_q;
  assign ena_up  = ena_up_q;
  assign ena_dw  = ena_dw_q;
  assign gt_mod  = mode_q;
  assign running = run_q;

endmodule

// File: tb/tb_dem_gpg_ctrl.sv
// Bench for dem_gpg_ctrl: directed steps plus random button
// activity, checked every cycle against a behavioural model.
module tb_dem_gpg_ctrl;

  localparam int DEB   = 4;
  localparam int P_DB  = 10;
  localparam int P_ADJ = 200;

  logic       ckht = 1'b0;
  logic       rst = 1'b0;
  logic       btn_run = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_dw = 1'b0;
  logic       ena_db, ena5hz, ena_up, ena_dw, running;
  logic [1:0] gt_mod;

  int checks = 0;
  int failures = 0;

  dem_gpg_ctrl #(
    .F_CLK(1000), .F_DB(100), .F_ADJ(5), .DEB_CYC(DEB)
  ) dut (
    .ckht(ckht), .rst(rst),
    .btn_run(btn_run), .btn_mode(btn_mode),
    .btn_up(btn_up), .btn_dw(btn_dw),
    .ena_db(ena_db), .ena5hz(ena5hz),
    .ena_up(ena_up), .ena_dw(ena_dw),
    .gt_mod(gt_mod), .running(running)
  );

  always #5 ckht = ~ckht;

  // Model: edge count since reset release and raw samples per edge
  int       n = 0;
  int       r_edge = 0;
  bit [3:0] hist [0:8191];
  bit [3:0] lvl_m = '0;
  bit [3:0] prs_m = '0;
  bit [1:0] mode_m = '0;
  bit       run_m = 1'b0;
  bit       e_db = 0, e_5 = 0, e_up = 0, e_dw = 0;

  function automatic bit [3:0] raw_at(int e);
    if (e < 1) return 4'b0000;
    return hist[e];
  endfunction

  task automatic model_edge();
    bit [1:0] old_mode;
    bit       old_run;
    bit [3:0] nl;
    if (!rst) begin
      n = 0; r_edge = 0; lvl_m = '0; prs_m = '0;
      mode_m = '0; run_m = 1'b0;
      e_db = 0; e_5 = 0; e_up = 0; e_dw = 0;
      return;
    end
    n++;
    hist[n] = {btn_dw, btn_up, btn_mode, btn_run};
    old_mode = mode_m;
    old_run  = run_m;
    if (prs_m[1]) mode_m = mode_m + 2'd1;
    if (old_mode == 2'd0 && prs_m[1]) run_m = 1'b0;
    if (old_mode == 2'd0 && prs_m[0] && !prs_m[1]) run_m = ~run_m;
    // Level flips once the synced input held the other value DEB samples
    nl = lvl_m;
    for (int b = 0; b < 4; b++) begin
      bit flip;
      bit [3:0] r;
      flip = 1'b1;
      for (int j = 0; j < DEB; j++) begin
        r = raw_at(n - 2 - j);
        if (r[b] == lvl_m[b]) flip = 1'b0;
      end
      if (flip) nl[b] = ~lvl_m[b];
    end
    prs_m = nl & ~lvl_m;
    lvl_m = nl;
    if (run_m && !old_run) r_edge = n;
    e_db = old_run && run_m && ((n - r_edge) % P_DB == 0);
    e_5  = (n % P_ADJ == 0);
    e_up = lvl_m[2] && !lvl_m[3] && (mode_m != 2'd0);
    e_dw = lvl_m[3] && !lvl_m[2] && (mode_m != 2'd0);
  endtask

  task automatic chk(string tag, logic [1:0] got, logic [1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all();
    chk("ena_db",  {1'b0, ena_db},  {1'b0, e_db});
    chk("ena5hz",  {1'b0, ena5hz},  {1'b0, e_5});
    chk("ena_up",  {1'b0, ena_up},  {1'b0, e_up});
    chk("ena_dw",  {1'b0, ena_dw},  {1'b0, e_dw});
    chk("gt_mod",  gt_mod,          mode_m);
    chk("running", {1'b0, running}, {1'b0, run_m});
  endtask

  task automatic tick();
    @(posedge ckht);
    model_edge();
    #1;
    chk_all();
  endtask

  task automatic ticks(int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic set_btn(bit [3:0] v);
    btn_run  = v[0];
    btn_mode = v[1];
    btn_up   = v[2];
    btn_dw   = v[3];
  endtask

  task automatic press(bit [3:0] v);
    set_btn(v);
    ticks(8);
    set_btn(4'b0000);
    ticks(8);
  endtask

  initial begin
    int hold [4];
    bit [3:0] rb;

    // Reset state
    ticks(3);
    rst = 1'b1;

    // Start: run press held 8 cycles
    set_btn(4'b0001);
    ticks(8);
    set_btn(4'b0000);
    ticks(30);
    chk("start_running", {1'b0, running}, 2'b01);

    // Bouncing up button in normal mode
    for (int i = 0; i < 10; i++) begin
      btn_up = ~btn_up;
      ticks(2);
    end
    btn_up = 1'b1;
    ticks(12);
    chk("norm_up_blocked", {1'b0, ena_up}, 2'b00);
    btn_up = 1'b0;
    ticks(10);

    // Full mode cycle
    for (int i = 0; i < 4; i++) press(4'b0010);
    chk("mode_wrap", gt_mod, 2'b00);
    chk("mode_stop", {1'b0, running}, 2'b00);

    // Minutes mode: both held, then up alone
    press(4'b0010);
    press(4'b0010);
    set_btn(4'b1100);
    ticks(10);
    chk("both_up", {1'b0, ena_up}, 2'b00);
    chk("both_dw", {1'b0, ena_dw}, 2'b00);
    btn_dw = 1'b0;
    ticks(7);
    chk("up_only", {1'b0, ena_up}, 2'b01);
    ticks(420);
    set_btn(4'b0000);
    ticks(8);

    // Run ignored outside normal mode
    press(4'b0010);
    press(4'b0010);
    press(4'b0010);
    chk("in_sec", gt_mod, 2'b01);
    press(4'b0001);
    chk("sec_run_ignored", {1'b0, running}, 2'b00);
    press(4'b0010);
    press(4'b0010);
    press(4'b0010);
    press(4'b0001);
    chk("run_again", {1'b0, running}, 2'b01);
    ticks(25);
    press(4'b0011);
    chk("simul_mode", gt_mod, 2'b01);
    chk("simul_run", {1'b0, running}, 2'b00);

    // Random button activity
    for (int b = 0; b < 4; b++) hold[b] = 0;
    for (int c = 0; c < 800; c++) begin
      rb = {btn_dw, btn_up, btn_mode, btn_run};
      for (int b = 0; b < 4; b++) begin
        if (hold[b] == 0) begin
          rb[b] = 1'($urandom_range(0, 1));
          hold[b] = $urandom_range(1, 12);
        end else begin
          hold[b]--;
        end
      end
      set_btn(rb);
      tick();
    end
    set_btn(4'b0000);
    ticks(10);

    // Asynchronous reset mid-debounce and mid-prescale
    btn_up = 1'b1;
    ticks(3);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_db",   {1'b0, ena_db},  2'b00);
    chk("arst_5hz",  {1'b0, ena5hz},  2'b00);
    chk("arst_up",   {1'b0, ena_up},  2'b00);
    chk("arst_dw",   {1'b0, ena_dw},  2'b00);
    chk("arst_mod",  gt_mod,          2'b00);
    chk("arst_run",  {1'b0, running}, 2'b00);
    ticks(3);
    rst = 1'b1;
    ticks(199);
    chk("pre_5hz", {1'b0, ena5hz}, 2'b00);
    tick();
    chk("first_5hz", {1'b0, ena5hz}, 2'b01);
    btn_up = 1'b0;
    ticks(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
